// File: rtl/sum_bcd_display_if.sv
// Load/result bus between the adder datapath and the BCD display stage.
// The master drives a binary sum plus load strobe; the slave returns busy and the committed BCD value.
interface sum_bcd_display_if #(
  parameter int DATA_W = 9
);
  logic              load_i;
  logic [DATA_W-1:0] data_i;
  logic              busy_o;
  logic [15:0]       bcd_o;

  modport master (output load_i, data_i, input busy_o, bcd_o);
  modport slave  (input load_i, data_i, output busy_o, bcd_o);
endinterface

// File: rtl/sum_bcd_display.sv
// Captures a binary sum, converts it to 4-digit BCD with a sequential double-dabble engine, and
// scans it onto a common-anode 7-segment panel. Define SUM_DISP_LEADING_ZERO_BLANK_EN to blank leading zeros.
module sum_bcd_display #(
  parameter int DATA_W      = 9,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  sum_bcd_display_if.slave    bus,
  output logic [3:0]          an_o,
  output logic [6:0]          seg_o,
  output logic                dp_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] shift_q, shift_next;
  logic [15:0]       scratch_q, scratch_next, adjusted;
  logic [3:0]        iter_q, iter_next;
  logic [15:0]       bcd_q, bcd_next;

  // Active-low gfedcba; codes above 9 never occur and stay dark.
  function automatic logic [6:0] decode(input logic [3:0] digit);
    case (digit)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // NOTE: every signal gets its default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    scratch_next = scratch_q;
    iter_next    = iter_q;
    bcd_next     = bcd_q;
    adjusted     = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    case (state)
      IDLE: begin
        if (bus.load_i) begin
          shift_next   = bus.data_i;
          scratch_next = '0;
          iter_next    = 4'(DATA_W);
          state_next   = CONV;
        end
      end
      CONV: begin
        {scratch_next, shift_next} = {adjusted, shift_q} << 1;
        iter_next                  = iter_q - 4'd1;
        // The last iteration commits straight to the display register, so bcd_o never shows a partial value.
        if (iter_q == 4'd1) begin
          bcd_next   = scratch_next;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd_q     <= '0;
    end else begin
      state     <= state_next;
      shift_q   <= shift_next;
      scratch_q <= scratch_next;
      iter_q    <= iter_next;
      bcd_q     <= bcd_next;
    end
  end

  assign bus.busy_o = (state == CONV);
  assign bus.bcd_o  = bcd_q;
  assign dp_o       = 1'b1;

  logic [CNT_W-1:0] refresh_q;
  logic [1:0]       digit_q;
  logic [3:0]       nibble;
  logic             blank;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;

  always_comb begin
    nibble = bcd_q[{digit_q, 2'b00} +: 4];
    blank  = 1'b0;
`ifdef SUM_DISP_LEADING_ZERO_BLANK_EN
    // A digit is dark when it and everything above it are zero; the ones digit always shows.
    blank  = (digit_q != 2'd0) && ((bcd_q >> {digit_q, 2'b00}) == 16'h0000);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      digit_q   <= '0;
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
    end else begin
      if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_q <= '0;
        digit_q   <= digit_q + 2'd1;
      end else begin
        refresh_q <= refresh_q + CNT_W'(1);
      end
      an_q  <= blank ? 4'b1111 : ~(4'b0001 << digit_q);
      seg_q <= blank ? 7'h7F : decode(nibble);
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Directed bench for sum_bcd_display with DATA_W=9 and REFRESH_DIV=4; expected values are hand-computed.
module tb_sum_bcd_display;

  logic       clk;
  logic       rst_n;
  logic [3:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;
  int         checks;
  int         errors;

  sum_bcd_display_if #(.DATA_W(9)) bus ();

  sum_bcd_display #(.DATA_W(9), .REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .an_o  (an_o),
    .seg_o (seg_o),
    .dp_o  (dp_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (bus.busy_o === 1'b1 && cycles < 20);
  endtask

  task automatic convert(input logic [8:0] value, input logic [15:0] exp_bcd, input string tag);
    int cycles;
    bus.load_i = 1'b1;
    bus.data_i = value;
    step();
    bus.load_i = 1'b0;
    check({tag, " busy_rise"}, 32'(bus.busy_o), 32'd1);
    wait_idle(cycles);
    check({tag, " busy_len"}, 32'(cycles), 32'd9);
    check({tag, " bcd"}, 32'(bus.bcd_o), 32'(exp_bcd));
  endtask

  initial begin
    logic [10:0] scan_exp [4];
    logic [3:0]  prev_an;
    int          cycles;
    bit          found;

    checks      = 0;
    errors      = 0;
    rst_n       = 1'b1;
    bus.load_i  = 1'b0;
    bus.data_i  = '0;

    // Asynchronous reset: values must appear without any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", 32'(bus.busy_o), 32'd0);
    check("rst bcd",  32'(bus.bcd_o),  32'h0000);
    check("rst an",   32'(an_o),       32'hF);
    check("rst seg",  32'(seg_o),      32'h7F);
    check("rst dp",   32'(dp_o),       32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("post_rst an",  32'(an_o),  32'b1110);
    check("post_rst seg", 32'(seg_o), 32'b1000000);

    convert(9'd255, 16'h0255, "conv255");
    convert(9'd511, 16'h0511, "conv511");
    convert(9'd0,   16'h0000, "conv0");
    convert(9'd1,   16'h0001, "conv1");
    convert(9'd99,  16'h0099, "conv99");

    // Load while busy: the second strobe must be ignored.
    bus.load_i = 1'b1;
    bus.data_i = 9'd100;
    step();
    check("busy_load busy", 32'(bus.busy_o), 32'd1);
    bus.data_i = 9'd7;
    step();
    bus.load_i = 1'b0;
    wait_idle(cycles);
    check("busy_load len", 32'(cycles), 32'd8);
    check("busy_load bcd", 32'(bus.bcd_o), 32'h0100);

    convert(9'd255, 16'h0255, "conv255b");

    // Scanner: align to the first cycle of the ones-digit slot, then check 16 cycles.
    scan_exp[0] = {4'b1110, 7'b0010010};
    scan_exp[1] = {4'b1101, 7'b0010010};
    scan_exp[2] = {4'b1011, 7'b0100100};
`ifdef SUM_DISP_LEADING_ZERO_BLANK_EN
    scan_exp[3] = {4'b1111, 7'b1111111};
`else
    scan_exp[3] = {4'b0111, 7'b1000000};
`endif
    found   = 1'b0;
    prev_an = an_o;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (an_o === 4'b1110 && prev_an !== 4'b1110) found = 1'b1;
      else prev_an = an_o;
    end
    check("scan align", 32'(found), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("scan cyc%0d", i), 32'({an_o, seg_o}), 32'(scan_exp[i / 4]));
      step();
    end
    check("scan dp", 32'(dp_o), 32'd1);

    // Reset during iteration 4 of converting 300 aborts without committing.
    bus.load_i = 1'b1;
    bus.data_i = 9'd300;
    step();
    bus.load_i = 1'b0;
    repeat (3) step();
    check("abort busy_pre", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy_o), 32'd0);
    check("abort bcd",  32'(bus.bcd_o),  32'h0000);
    repeat (2) step();
    @(negedge clk) rst_n = 1'b1;
    repeat (12) step();
    check("abort idle", 32'(bus.busy_o), 32'd0);
    check("abort hold", 32'(bus.bcd_o),  32'h0000);
    convert(9'd300, 16'h0300, "conv300");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_bcd_display.md
Name: sum_bcd_display

Overview:
- Display stage downstream of the adder datapath: captures a binary sum on a load strobe and converts it to 4-digit BCD with a sequential double-dabble engine.
- Drives a 4-digit multiplexed, common-anode seven-segment display through a refresh scanner.
- The display register updates atomically, so the panel never shows a partially converted value.

Parameters:
- DATA_W, 9, width of the binary input. Legal range 1..13, so the result always fits in 4 BCD digits.
- REFRESH_DIV, 100000, clock cycles per digit slot. Must be ≥1; 1 advances the digit every cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_i  in  1  one-cycle strobe that captures data_i; honoured only while idle.
- data_i  in  DATA_W  unsigned binary sum from the adder.
- busy_o  out  1  high while a conversion is in progress.
- bcd_o  out  16  displayed BCD value; [3:0] = ones, [15:12] = thousands.
- an_o  out  4  digit anodes, active-low; an_o[0] = ones digit.
- seg_o  out  7  segments, active-low; bit order {g,f,e,d,c,b,a}.
- dp_o  out  1  decimal point, active-low; constant 1 (off).

Behaviour:
- Reset, asynchronous, values while rst_n is low: busy_o=0, bcd_o=16'h0000, an_o=4'b1111, seg_o=7'h7F, dp_o=1, digit index=0, refresh counter=0, FSM in IDLE.
- Reset asserted mid-conversion aborts the conversion; no partial result is ever committed.
- FSM states: IDLE, CONV.
  - IDLE: when load_i=1 at edge N, capture data_i into the shift register, clear the BCD scratch, set the iteration count to DATA_W, go to CONV.
  - CONV: each edge performs one iteration: add 3 to every scratch nibble ≥5, then shift {scratch, shift register} left by 1.
  - The DATA_W-th iteration completes at edge N+DATA_W. Its result is written directly to bcd_o on that edge, and the FSM returns to IDLE.
- busy_o is registered and equals (state==CONV): high after edge N, low after edge N+DATA_W. Latency from load to bcd_o update is DATA_W cycles.
- load_i is ignored while busy_o=1. No queueing, no error flag.
- load_i asserted in the same cycle busy_o falls is honoured, since the FSM is already in IDLE.
- Scanner:
  - Refresh counter runs 0..REFRESH_DIV-1. On wrap, the digit index increments modulo 4 (0→1→2→3→0).
  - an_o and seg_o are registered together on the same edge: an_o = ~(1<<index), seg_o = decode(bcd_o nibble[index]).
  - The first edge after reset release drives an_o=4'b1110.
  - A bcd_o change is reflected on the next edge for the currently selected digit.
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10..15 are unreachable; decode them to 1111111.
- Conversion and scanning run independently; scanning continues during CONV using the previous bcd_o.

Optional Feature:
- Macro: SUM_DISP_LEADING_ZERO_BLANK_EN.
- Defined: any digit above the most significant nonzero digit is blanked (an_o bit held 1, seg_o=7'h7F during its slot). The ones digit is never blanked, so value 0 shows a single "0". bcd_o itself is unaffected.
- Undefined: all four digits are always lit, with leading zeros shown.

Test Plan:
- Reset: rst_n low for 3 cycles, released asynchronously mid-cycle -> outputs take reset values immediately; one edge after release an_o=1110, seg_o=1000000.
- DATA_W=9, load_i with data_i=255 -> busy_o high for exactly 9 cycles; bcd_o=16'h0255 at edge N+9.
- Boundary values: load 511 -> 16'h0511; load 0 -> 16'h0000; load 1 -> 16'h0001; back-to-back loads on busy_o fall each convert correctly.
- Load while busy: load 100, then load 7 one cycle later -> 7 ignored; bcd_o=16'h0100.
- Scanner, REFRESH_DIV=4, bcd_o=0x0255 -> required sequence, each held 4 cycles, then repeating:
  - an_o=1110, seg_o=0010010
  - an_o=1101, seg_o=0010010
  - an_o=1011, seg_o=0100100
  - an_o=0111, seg_o=1000000 (macro undefined) or an_o=1111, seg_o=1111111 (macro defined)
- Reset at iteration 4 of a conversion of 300 -> bcd_o stays 0; after release, load 300 -> bcd_o=16'h0300.
